// File: rtl/instr_mem_encoder.sv
// Y86-64 instruction encoder: serialises decoded fields into instruction-memory bytes, one byte per cycle.
// Optional INSTR_PAD10_EN pads every instruction to 10 bytes with nop (8'h10).
module instr_mem_encoder #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        set_ptr_i,
    input  logic [63:0] ptr_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [3:0]  icode_i,
    input  logic [3:0]  ifun_i,
    input  logic [3:0]  rA_i,
    input  logic [3:0]  rB_i,
    input  logic [63:0] valC_i,
    output logic        wr_en_o,
    output logic [63:0] wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic [63:0] wr_ptr_o,
    output logic [15:0] instr_cnt_o,
    output logic        invalid_o,
    output logic        mem_error_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [64:0] MEM_LIMIT = 65'(MEM_DEPTH);

    function automatic logic need_regids(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            default:                                  need_regids = 1'b0;
        endcase
    endfunction

    function automatic logic need_valc(input logic [3:0] ic);
        case (ic)
            4'h3, 4'h4, 4'h5, 4'h7, 4'h8: need_valc = 1'b1;
            default:                      need_valc = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] nat_len(input logic [3:0] ic);
        nat_len = 4'd1 + {3'd0, need_regids(ic)} + (need_valc(ic) ? 4'd8 : 4'd0);
    endfunction

    // Byte idx of an encoded instruction; indices past the natural length are nop padding.
    function automatic logic [7:0] enc_byte(input logic [3:0] idx, input logic [3:0] ic,
                                            input logic [3:0] ifn, input logic [3:0] ra,
                                            input logic [3:0] rb, input logic [63:0] valc);
        logic       nr;
        logic [3:0] vidx;
        nr   = need_regids(ic);
        vidx = idx - 4'd1 - {3'd0, nr};
        if (idx == 4'd0) begin
            enc_byte = {ic, ifn};
        end else if (nr && (idx == 4'd1)) begin
            enc_byte = {ra, rb};
        end else if (idx < nat_len(ic)) begin
            enc_byte = 8'(valc >> {vidx, 3'b000});
        end else begin
            enc_byte = 8'h10;
        end
    endfunction

    state_t      r_state;
    logic [63:0] r_ptr;
    logic [15:0] r_cnt;
    logic        r_wr_en;
    logic [63:0] r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_invalid;
    logic        r_mem_err;
    logic [3:0]  r_icode;
    logic [3:0]  r_ifun;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic [63:0] r_valc;
    logic [3:0]  r_len;
    logic [3:0]  r_idx;

    logic [3:0]  w_len;
    logic [64:0] w_end;
    logic        w_overflow;
    logic [7:0]  w_byte0;
    logic [7:0]  w_next_byte;

`ifdef INSTR_PAD10_EN
    assign w_len = 4'd10;
`else
    assign w_len = nat_len(icode_i);
`endif

    // Full-width sum so a pointer near 2^64 cannot wrap past the bound check.
    assign w_end       = {1'b0, r_ptr} + {61'd0, w_len};
    assign w_overflow  = (w_end > MEM_LIMIT);
    assign w_byte0     = enc_byte(4'd0, icode_i, ifun_i, rA_i, rB_i, valC_i);
    assign w_next_byte = enc_byte(r_idx + 4'd1, r_icode, r_ifun, r_ra, r_rb, r_valc);

    assign in_ready_o  = (r_state == S_IDLE) & ~set_ptr_i;
    assign wr_en_o     = r_wr_en;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;
    assign wr_ptr_o    = r_ptr;
    assign instr_cnt_o = r_cnt;
    assign invalid_o   = r_invalid;
    assign mem_error_o = r_mem_err;

    // Encoder FSM: accept, bound-check, then stream one byte per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_ptr     <= 64'd0;
            r_cnt     <= 16'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 64'd0;
            r_wr_data <= 8'd0;
            r_invalid <= 1'b0;
            r_mem_err <= 1'b0;
            r_icode   <= 4'd0;
            r_ifun    <= 4'd0;
            r_ra      <= 4'd0;
            r_rb      <= 4'd0;
            r_valc    <= 64'd0;
            r_len     <= 4'd0;
            r_idx     <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wr_en <= 1'b0;
                    if (set_ptr_i) begin
                        r_ptr     <= ptr_i;
                        r_invalid <= 1'b0;
                        r_mem_err <= 1'b0;
                    end else if (in_valid_i) begin
                        if (icode_i >= 4'hC) begin
                            r_invalid <= 1'b1;
                            r_state   <= S_ERR;
                        end else if (w_overflow) begin
                            r_mem_err <= 1'b1;
                            r_state   <= S_ERR;
                        end else begin
                            r_icode   <= icode_i;
                            r_ifun    <= ifun_i;
                            r_ra      <= rA_i;
                            r_rb      <= rB_i;
                            r_valc    <= valC_i;
                            r_len     <= w_len;
                            r_idx     <= 4'd0;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_ptr;
                            r_wr_data <= w_byte0;
                            r_state   <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (r_idx == (r_len - 4'd1)) begin
                        r_wr_en <= 1'b0;
                        r_ptr   <= r_ptr + {60'd0, r_len};
                        r_cnt   <= r_cnt + 16'd1;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx     <= r_idx + 4'd1;
                        r_wr_addr <= r_wr_addr + 64'd1;
                        r_wr_data <= w_next_byte;
                    end
                end
                S_ERR: begin
                    r_wr_en <= 1'b0;
                    if (set_ptr_i) begin
                        r_ptr     <= ptr_i;
                        r_invalid <= 1'b0;
                        r_mem_err <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_wr_en <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_encoder.sv
// Scoreboard bench for instr_mem_encoder: expected bytes are queued as stimulus is driven
// and checked against every write strobe.
module tb_instr_mem_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_ptr;
    logic [63:0] ptr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [7:0]  wr_data;
    logic [63:0] wr_ptr;
    logic [15:0] instr_cnt;
    logic        invalid;
    logic        mem_error;

    int checks = 0;
    int errors = 0;
    logic [71:0] sb[$];
    logic [63:0] exp_ptr = 64'd0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    instr_mem_encoder dut (
        .clk_i(clk), .rst_i(rst), .set_ptr_i(set_ptr), .ptr_i(ptr),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .icode_i(icode), .ifun_i(ifun), .rA_i(ra), .rB_i(rb), .valC_i(valc),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .wr_ptr_o(wr_ptr), .instr_cnt_o(instr_cnt),
        .invalid_o(invalid), .mem_error_o(mem_error)
    );

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    // Model of the byte stream for one instruction; queues at most max_b bytes.
    function automatic void push_instr(input logic [3:0] ic, input logic [3:0] fn,
                                       input logic [3:0] a, input logic [3:0] b,
                                       input logic [63:0] c, input int max_b);
        logic [7:0] bytes[10];
        int n;
        for (int i = 0; i < 10; i++) bytes[i] = 8'h00;
        bytes[0] = {ic, fn};
        n = 1;
        if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
            bytes[n] = {a, b};
            n++;
        end
        if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) begin
            for (int k = 0; k < 8; k++) begin
                bytes[n] = c[8*k +: 8];
                n++;
            end
        end
`ifdef INSTR_PAD10_EN
        while (n < 10) begin
            bytes[n] = 8'h10;
            n++;
        end
`endif
        for (int i = 0; i < n && i < max_b; i++) sb.push_back({exp_ptr + 64'(i), bytes[i]});
        exp_ptr = exp_ptr + 64'(n);
        exp_cnt = exp_cnt + 16'd1;
    endfunction

    // Every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            logic [71:0] e;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", wr_addr, wr_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", wr_addr, e[71:8]);
                chk("wr_data", {56'd0, wr_data}, {56'd0, e[7:0]});
            end
        end
    end

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                         input logic [3:0] b, input logic [63:0] c);
        icode = ic; ifun = fn; ra = a; rb = b; valc = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load_ptr(input logic [63:0] p);
        set_ptr = 1'b1;
        ptr = p;
        @(posedge clk); #1;
        set_ptr = 1'b0;
        exp_ptr = p;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 40);
        chk(tag, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; set_ptr = 1'b0; ptr = 64'd0; in_valid = 1'b0;
        icode = 4'd0; ifun = 4'd0; ra = 4'd0; rb = 4'd0; valc = 64'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_wr_addr", wr_addr, 64'd0);
        chk("rst_wr_data", {56'd0, wr_data}, 64'd0);
        chk("rst_wr_ptr", wr_ptr, 64'd0);
        chk("rst_cnt", {48'd0, instr_cnt}, 64'd0);
        chk("rst_invalid", {63'd0, invalid}, 64'd0);
        chk("rst_mem_error", {63'd0, mem_error}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);

        // irmovq $8, %r8 at address 0
        push_instr(4'h3, 4'h0, 4'hF, 4'h8, 64'd8, 10);
        drive(4'h3, 4'h0, 4'hF, 4'h8, 64'd8);
        wait_idle("irmovq_done");
        chk("irmovq_ptr", wr_ptr, exp_ptr);
        chk("irmovq_cnt", {48'd0, instr_cnt}, {48'd0, exp_cnt});

        // opq then pushq back-to-back with in_valid held high
        load_ptr(64'd30);
        push_instr(4'h6, 4'h1, 4'h2, 4'h3, 64'd0, 10);
        icode = 4'h6; ifun = 4'h1; ra = 4'h2; rb = 4'h3; valc = 64'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        push_instr(4'hA, 4'h0, 4'h2, 4'hF, 64'd0, 10);
        icode = 4'hA; ifun = 4'h0; ra = 4'h2; rb = 4'hF;
        @(negedge clk);
        chk("opq_ready_low", {63'd0, in_ready}, 64'd0);
        for (int n = 0; n < 40 && !in_ready; n++) @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pushq_ready_low", {63'd0, in_ready}, 64'd0);
        wait_idle("pushq_done");
        chk("b2b_ptr", wr_ptr, exp_ptr);
        chk("b2b_cnt", {48'd0, instr_cnt}, {48'd0, exp_cnt});

        // invalid icode is rejected and sticks until a pointer load
        drive(4'hC, 4'h0, 4'h0, 4'h0, 64'd0);
        repeat (3) @(negedge clk);
        chk("inv_flag", {63'd0, invalid}, 64'd1);
        chk("inv_ready", {63'd0, in_ready}, 64'd0);
        chk("inv_ptr", wr_ptr, exp_ptr);
        load_ptr(64'd0);
        @(negedge clk);
        chk("inv_clear", {63'd0, invalid}, 64'd0);
        chk("inv_ready_back", {63'd0, in_ready}, 64'd1);

        // rmmovq at 1020 overruns memory; at 1014 it fits exactly
        load_ptr(64'd1020);
        drive(4'h4, 4'h0, 4'h0, 4'h3, 64'd1);
        repeat (3) @(negedge clk);
        chk("mem_err_flag", {63'd0, mem_error}, 64'd1);
        chk("mem_err_ready", {63'd0, in_ready}, 64'd0);
        chk("mem_err_ptr", wr_ptr, 64'd1020);
        load_ptr(64'd1014);
        @(negedge clk);
        chk("mem_err_clear", {63'd0, mem_error}, 64'd0);
        push_instr(4'h4, 4'h0, 4'h0, 4'h3, 64'd1, 10);
        drive(4'h4, 4'h0, 4'h0, 4'h3, 64'd1);
        wait_idle("rmmovq_done");
        chk("rmmovq_ptr", wr_ptr, 64'd1024);
        chk("rmmovq_cnt", {48'd0, instr_cnt}, {48'd0, exp_cnt});

        // halt at address 0
        load_ptr(64'd0);
        push_instr(4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 10);
        drive(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
        wait_idle("halt_done");
        chk("halt_ptr", wr_ptr, exp_ptr);

        // reset after the third byte of an irmovq
        load_ptr(64'd0);
        push_instr(4'h3, 4'h0, 4'hF, 4'h8, 64'h1122334455667788, 3);
        drive(4'h3, 4'h0, 4'hF, 4'h8, 64'h1122334455667788);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ptr = 64'd0;
        exp_cnt = 16'd0;
        @(negedge clk);
        chk("abort_wr_en", {63'd0, wr_en}, 64'd0);
        chk("abort_ptr", wr_ptr, 64'd0);
        chk("abort_cnt", {48'd0, instr_cnt}, 64'd0);
        chk("abort_ready", {63'd0, in_ready}, 64'd1);

        // encoder is usable again after the abort
        push_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'd0, 10);
        drive(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
        wait_idle("nop_done");
        chk("nop_ptr", wr_ptr, exp_ptr);
        chk("nop_cnt", {48'd0, instr_cnt}, 64'd1);

        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
